// File: rtl/bb_header_checker_pkg.sv
// Shared constants, state encoding and helpers
// for the DVB-S2 BBHEADER checker.
package bb_header_checker_pkg;

  localparam int HDR_LEN    = 10;
  localparam int OFF_MATYPE = 0;
  localparam int OFF_UPL    = 2;
  localparam int OFF_DFL    = 4;
  localparam int OFF_SYNC   = 6;
  localparam int OFF_SYNCD  = 7;
  localparam int OFF_CRC    = 9;

  localparam logic [7:0] CRC_POLY = 8'hD5;
  localparam logic [7:0] MODE_XOR = 8'h01;
  localparam logic [3:0] CNT_LAST = 4'(OFF_CRC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REPORT
  } state_t;

  function automatic logic [15:0] be16(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/bb_header_checker_if.sv
// Byte-stream input and decoded-header output
// bundle of the BBHEADER checker.
interface bb_header_checker_if;

  logic        ENA;
  logic        SOF;
  logic [7:0]  DIN;
  logic        HDR_STROBE;
  logic        CRC_OK;
  logic        HEM;
  logic        CRC_ERR;
  logic [15:0] MATYPE;
  logic [15:0] UPL;
  logic [15:0] DFL;
  logic [7:0]  SYNC;
  logic [15:0] SYNCD;

  modport master (
    output ENA, SOF, DIN,
    input  HDR_STROBE, CRC_OK, HEM, CRC_ERR,
    input  MATYPE, UPL, DFL, SYNC, SYNCD
  );

  modport slave (
    input  ENA, SOF, DIN,
    output HDR_STROBE, CRC_OK, HEM, CRC_ERR,
    output MATYPE, UPL, DFL, SYNC, SYNCD
  );

endinterface

// File: rtl/bb_header_checker_crc8_d5_byte.sv
// Byte-wide CRC-8 (poly 0xD5) update step,
// MSB first, no reflection.
module crc8_d5_byte
  import bb_header_checker_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] nxt
);

  logic [7:0] c;

  always_comb begin
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^
          ((c[7] ^ data[i]) ? CRC_POLY : 8'h00);
    end
    nxt = c;
  end

endmodule

// File: rtl/bb_header_checker.sv
// BBHEADER collector: shadows 10 bytes, checks
// CRC-8 xor mode, reports fields on a strobe.
module bb_header_checker
  import bb_header_checker_pkg::*;
#(
  parameter bit HOLD_ON_ERR = 1'b0
) (
  input logic CLK,
  input logic RST,
  bb_header_checker_if.slave bus
);

  state_t state;
  state_t state_n;

  logic [3:0]  cnt;
  logic [7:0]  crc;
  logic [7:0]  crc_in;
  logic [7:0]  crc_nx;
  logic [7:0]  shadow [HDR_LEN-1];

  logic take_sof;
  logic take_byte;
  logic last;
  logic is_nm;
  logic is_hem;
  logic pass;

  logic        strobe_q;
  logic        ok_q;
  logic        hem_q;
  logic        err_q;
  logic [15:0] matype_q;
  logic [15:0] upl_q;
  logic [15:0] dfl_q;
  logic [7:0]  sync_q;
  logic [15:0] syncd_q;

  assign take_sof  = bus.ENA & bus.SOF;
  assign take_byte = bus.ENA & ~bus.SOF &
                     (state == ST_COLLECT);
  assign last      = take_byte & (cnt == CNT_LAST);

  // SOF restarts the CRC from zero in the same cycle
  assign crc_in = take_sof ? 8'h00 : crc;

  assign is_nm  = bus.DIN == crc;
  assign is_hem = bus.DIN == (crc ^ MODE_XOR);
  assign pass   = is_nm | is_hem;

  crc8_d5_byte u_crc (
    .crc  (crc_in),
    .data (bus.DIN),
    .nxt  (crc_nx)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      take_sof: state_n = ST_COLLECT;
      last:     state_n = ST_REPORT;
      (state == ST_REPORT && !take_sof):
                state_n = ST_IDLE;
      default:  state_n = state;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= 4'd0;
      crc      <= 8'h00;
      for (int i = 0; i < HDR_LEN-1; i++)
        shadow[i] <= 8'h00;
      strobe_q <= 1'b0;
      ok_q     <= 1'b0;
      hem_q    <= 1'b0;
      err_q    <= 1'b0;
      matype_q <= 16'h0;
      upl_q    <= 16'h0;
      dfl_q    <= 16'h0;
      sync_q   <= 8'h0;
      syncd_q  <= 16'h0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      if (take_sof) begin
        shadow[0] <= bus.DIN;
        crc       <= crc_nx;
        cnt       <= 4'd1;
      end else if (last) begin
        cnt      <= 4'd0;
        strobe_q <= 1'b1;
        ok_q     <= pass;
        err_q    <= ~pass;
        if (pass) hem_q <= is_hem;
        if (pass || !HOLD_ON_ERR) begin
          matype_q <= be16(shadow[OFF_MATYPE],
                           shadow[OFF_MATYPE+1]);
          upl_q    <= be16(shadow[OFF_UPL],
                           shadow[OFF_UPL+1]);
          dfl_q    <= be16(shadow[OFF_DFL],
                           shadow[OFF_DFL+1]);
          sync_q   <= shadow[OFF_SYNC];
          syncd_q  <= be16(shadow[OFF_SYNCD],
                           shadow[OFF_SYNCD+1]);
        end
      end else if (take_byte) begin
        shadow[cnt] <= bus.DIN;
        crc         <= crc_nx;
        cnt         <= cnt + 4'd1;
      end
    end
  end

  assign bus.HDR_STROBE = strobe_q;
  assign bus.CRC_OK     = ok_q;
  assign bus.HEM        = hem_q;
  assign bus.CRC_ERR    = err_q;
  assign bus.MATYPE     = matype_q;
  assign bus.UPL        = upl_q;
  assign bus.DFL        = dfl_q;
  assign bus.SYNC       = sync_q;
  assign bus.SYNCD      = syncd_q;

endmodule

// File: doc/bb_header_checker.md
BB_HEADER_CHECKER -- requirements
Module: bb_header_checker

Interface
REQ-001 The block SHALL have parameter HOLD_ON_ERR, default 0: when 1, the field outputs are not updated by a header that fails its CRC check.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port ENA, input, 1 bit: DIN carries a valid byte this cycle.
REQ-005 The block SHALL have port SOF, input, 1 bit: DIN is byte 0 of a BBHEADER; it is qualified by ENA.
REQ-006 The block SHALL have port DIN, input, 8 bits: header byte, MSB first on the wire.
REQ-007 The block SHALL have port HDR_STROBE, output, 1 bit: one-cycle pulse marking a completed header.
REQ-008 The block SHALL have port CRC_OK, output, 1 bit: the last completed header passed the check.
REQ-009 The block SHALL have port HEM, output, 1 bit: the last passing header was High Efficiency Mode (0 = Normal Mode).
REQ-010 The block SHALL have port CRC_ERR, output, 1 bit: one-cycle pulse with HDR_STROBE when the check fails.
REQ-011 The block SHALL have ports MATYPE (16 bits), UPL (16 bits), DFL (16 bits), SYNC (8 bits) and SYNCD (16 bits), all outputs: the header fields.

Function
REQ-012 The header SHALL be 10 bytes: MATYPE (bytes 0-1), UPL or ISSY raw (bytes 2-3), DFL (4-5), SYNC (6), SYNCD (7-8), CRC-8 XOR MODE (9); multi-byte fields are big-endian.
REQ-013 The CRC SHALL be CRC-8 with polynomial 0xD5, init 0x00, no input or output reflection, final XOR 0x00, computed byte-serially over bytes 0-8.
REQ-014 The FSM SHALL have three states: IDLE, COLLECT and REPORT.
REQ-015 In any state, ENA=1 with SOF=1 SHALL load byte 0, clear the CRC to 0x00 then apply byte 0, set the byte counter to 1 and enter COLLECT.
REQ-016 ENA=1 with SOF=0 while in IDLE SHALL be ignored.
REQ-017 In COLLECT, each byte with ENA=1 and SOF=0 SHALL be accepted and the counter incremented; ENA=0 cycles SHALL hold all state, and gaps of any length are legal.
REQ-018 SOF during COLLECT SHALL abort the partial header with no strobe and no error, and SHALL restart at byte 0 with that byte.
REQ-019 Acceptance of byte 9 SHALL move the FSM to REPORT, and byte 9 SHALL NOT enter the CRC.
REQ-020 Byte 9 equal to the CRC SHALL give CRC_OK=1 and HEM=0.
REQ-021 Byte 9 equal to the CRC XOR 0x01 SHALL give CRC_OK=1 and HEM=1.
REQ-022 Any other value of byte 9 SHALL give CRC_OK=0 and CRC_ERR=1.
REQ-023 In REPORT, HDR_STROBE SHALL be 1 for exactly one cycle, the cycle after byte 9 is accepted (latency 1), with CRC_OK, HEM, CRC_ERR and the fields valid in that same cycle.
REQ-024 CRC_OK and HEM SHALL hold their values until the next HDR_STROBE; CRC_ERR SHALL be a pulse coincident with HDR_STROBE.
REQ-025 The field outputs SHALL update in the REPORT cycle, except that they SHALL hold their previous values when HOLD_ON_ERR=1 and the check fails.
REQ-026 REPORT SHALL return to IDLE after one cycle, unless ENA and SOF are both 1 in that cycle, in which case that byte is accepted as byte 0 and the FSM enters COLLECT (back-to-back headers, no lost byte).
REQ-027 A header SHALL be stored in a shadow byte buffer during collection so that the field outputs never show a partial header.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE, byte counter 0, CRC 0x00 and the shadow buffer to 0.
REQ-029 RST=1 at a clock edge SHALL force HDR_STROBE, CRC_OK, HEM, CRC_ERR and all field outputs to 0.
REQ-030 RST asserted mid-header SHALL discard the partial header with no strobe.
REQ-031 RST SHALL take priority over ENA and SOF in the same cycle.

Structure
REQ-032 The shared package SHALL hold the polynomial constant 0xD5, the header length 10, the field byte offsets, the mode XOR value 0x01 and the FSM state enumeration.
REQ-033 The design SHALL contain one sub-module, crc8_d5_byte: a combinational next-CRC function of the current CRC and the input byte.

Verification
REQ-034 Bench: ten 0x00 bytes, first with SOF -> one cycle after the last byte, HDR_STROBE=1, CRC_OK=1, HEM=0, all fields 0x0.
REQ-035 Bench: 00×8, 01, D5 -> CRC_OK=1, HEM=0, SYNCD=0x0001; the same header with last byte D4 -> CRC_OK=1, HEM=1.
REQ-036 Bench: 00×8, 01, 00 -> CRC_ERR=1, CRC_OK=0; with HOLD_ON_ERR=1, the fields keep the previous header's values.
REQ-037 Bench: SOF re-asserted at byte 5, then a full good header -> exactly one strobe, for the second header only.
REQ-038 Bench: random ENA gaps of 0-7 cycles inside a header, plus a back-to-back SOF in the REPORT cycle -> two strobes, both CRC_OK=1.
REQ-039 Bench: RST pulsed at byte 4, then a good header -> no strobe for the aborted header, one strobe for the good header, and all outputs 0 after reset.
